// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller driving the 6502 irq/nmi pins, with a 4-byte register window at BASE.
// Define IRQ_CTRL_NMI_EN to build the nmi_src synchronizer and NMI pulse stretcher.
module irq_ctrl #(
  parameter int          NSRC      = 8,
  parameter logic [15:0] BASE      = 16'hD000,
  parameter int          NMI_PULSE = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     addr,
  input  logic [7:0]      odata,
  input  logic            rw,
  input  logic            clk2,
  input  logic [NSRC-1:0] src,
  input  logic            nmi_src,
  output logic [7:0]      rdata,
  output logic            rsel,
  output logic            irq,
  output logic            nmi
);

  logic [NSRC-1:0] src_s1_r, src_s2_r, src_h_r;
  logic [NSRC-1:0] pending_r, enable_r, edge_r;
  logic [NSRC-1:0] pending_s, masked_s, clr_s, rise_s;
  logic            clk2_q_r, hit_s, commit_s, any_s, irq_r;
  logic [2:0]      idx_s;

  assign hit_s    = (addr[15:2] == BASE[15:2]);
  assign rsel     = hit_s & rw;
  // one commit per bus cycle: only the clk cycle in which phi2 rises
  assign commit_s = hit_s & ~rw & clk2 & ~clk2_q_r;
  assign rise_s   = src_s2_r & ~src_h_r;
  assign masked_s = pending_r & enable_r;
  assign any_s    = |masked_s;
  assign clr_s    = (commit_s && (addr[1:0] == 2'd0)) ? odata[NSRC-1:0] : {NSRC{1'b0}};

  // source synchronizers, edge history and phi2 history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_s1_r <= {NSRC{1'b0}};
      src_s2_r <= {NSRC{1'b0}};
      src_h_r  <= {NSRC{1'b0}};
      clk2_q_r <= 1'b0;
    end else begin
      src_s1_r <= src;
      src_s2_r <= src_s1_r;
      src_h_r  <= src_s2_r;
      clk2_q_r <= clk2;
    end
  end

  // next pending: edge bits latch with set-over-clear, level bits follow the source
  always_comb begin
    pending_s = pending_r;
    for (int i = 0; i < NSRC; i++) begin
      if (edge_r[i]) begin
        pending_s[i] = (pending_r[i] & ~clr_s[i]) | rise_s[i];
      end else begin
        pending_s[i] = src_s2_r[i];
      end
    end
  end

  // lowest-numbered enabled pending source
  always_comb begin
    idx_s = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (masked_s[i]) begin
        idx_s = 3'(i);
      end else begin
        idx_s = idx_s;
      end
    end
  end

  // control registers and the registered irq output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_r <= {NSRC{1'b0}};
      enable_r  <= {NSRC{1'b0}};
      edge_r    <= {NSRC{1'b1}};
      irq_r     <= 1'b1;
    end else begin
      pending_r <= pending_s;
      irq_r     <= ~any_s;
      if (commit_s && (addr[1:0] == 2'd1)) begin
        enable_r <= odata[NSRC-1:0];
      end
      if (commit_s && (addr[1:0] == 2'd2)) begin
        edge_r <= odata[NSRC-1:0];
      end
    end
  end

  assign irq = irq_r;

  // register read mux, zero when not selected
  always_comb begin
    rdata = 8'h00;
    if (rsel) begin
      case (addr[1:0])
        2'd0:    rdata = 8'(pending_r);
        2'd1:    rdata = 8'(enable_r);
        2'd2:    rdata = 8'(edge_r);
        2'd3:    rdata = {any_s, 4'b0000, idx_s};
        default: rdata = 8'h00;
      endcase
    end else begin
      rdata = 8'h00;
    end
  end

`ifdef IRQ_CTRL_NMI_EN
  localparam int CW = $clog2(NMI_PULSE);
  localparam logic [CW-1:0] CNT_LOAD = CW'(NMI_PULSE - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_PULSE = 1'b1} nmi_state_t;

  nmi_state_t    state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          nmi_s1_r, nmi_s2_r, nmi_h_r, nmi_r, nmi_s, nmi_rise_s;

  assign nmi_rise_s = nmi_s2_r & ~nmi_h_r;

  // nmi_src synchronizer and edge history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nmi_s1_r <= 1'b0;
      nmi_s2_r <= 1'b0;
      nmi_h_r  <= 1'b0;
    end else begin
      nmi_s1_r <= nmi_src;
      nmi_s2_r <= nmi_s1_r;
      nmi_h_r  <= nmi_s2_r;
    end
  end

  // pulse stretcher state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      nmi_r   <= 1'b1;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      nmi_r   <= nmi_s;
    end
  end

  // a new edge mid-pulse reloads the counter, so the low pulse just grows
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    nmi_s   = nmi_r;
    case (state_r)
      ST_IDLE: begin
        if (nmi_rise_s) begin
          state_s = ST_PULSE;
          cnt_s   = CNT_LOAD;
          nmi_s   = 1'b0;
        end else begin
          nmi_s   = 1'b1;
        end
      end
      ST_PULSE: begin
        if (nmi_rise_s) begin
          cnt_s = CNT_LOAD;
          nmi_s = 1'b0;
        end else if (cnt_r != {CW{1'b0}}) begin
          cnt_s = cnt_r - CW'(1'b1);
          nmi_s = 1'b0;
        end else begin
          state_s = ST_IDLE;
          nmi_s   = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CW{1'b0}};
        nmi_s   = 1'b1;
      end
    endcase
  end

  assign nmi = nmi_r;
`else
  logic unused_nmi_s;
  assign unused_nmi_s = nmi_src;
  assign nmi = 1'b1;
`endif

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: register table, directed corner sequences, then
// randomized traffic compared cycle by cycle against a history-based reference model.
module tb_irq_ctrl;
  localparam logic [15:0] BASE = 16'hD000;
  localparam int P = 4;

  logic        clk = 1'b0, reset = 1'b0, rw = 1'b1, clk2 = 1'b0, nmi_src = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  odata = 8'h00, src = 8'h00;
  logic [7:0]  rdata;
  logic        rsel, irq, nmi;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  irq_ctrl #(.NSRC(8), .BASE(BASE), .NMI_PULSE(P)) dut (
    .clk(clk), .reset(reset), .addr(addr), .odata(odata), .rw(rw), .clk2(clk2),
    .src(src), .nmi_src(nmi_src), .rdata(rdata), .rsel(rsel), .irq(irq), .nmi(nmi)
  );

  // reference model state: registers plus sampled input history (index 0 = last edge)
  logic [7:0] pend_m, en_m, edge_m;
  logic [7:0] sh [3];
  logic       nh [3];
  logic       irq_m, nmi_m, m_commit;
  logic [1:0] m_off;
  logic [7:0] m_data;
  int         cyc_n, last_nmi;
  bit         have_nmi;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    pend_m = 8'h00; en_m = 8'h00; edge_m = 8'hFF;
    irq_m = 1'b1; nmi_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sh[i] = 8'h00;
      nh[i] = 1'b0;
    end
    have_nmi = 1'b0; cyc_n = 0; last_nmi = 0;
  endtask

  // one clock of the model: a source counts two edges after it was sampled
  task automatic model_step();
    logic [7:0] clr, rise, lvl;
    logic       nmi_raw;
    if (!reset) begin
      model_clear();
      return;
    end
    cyc_n++;
    irq_m = ((pend_m & en_m) == 8'h00);
    lvl  = sh[1];
    rise = sh[1] & ~sh[2];
    clr  = (m_commit && m_off == 2'd0) ? m_data : 8'h00;
    pend_m = (edge_m & ((pend_m & ~clr) | rise)) | (~edge_m & lvl);
    if (m_commit && m_off == 2'd1) en_m = m_data;
    if (m_commit && m_off == 2'd2) edge_m = m_data;
    if (nh[1] && !nh[2]) begin
      have_nmi = 1'b1;
      last_nmi = cyc_n;
    end
    nmi_raw = !(have_nmi && (cyc_n - last_nmi) < P);
`ifdef IRQ_CTRL_NMI_EN
    nmi_m = nmi_raw;
`else
    nmi_m = 1'b1 | nmi_raw;
`endif
    sh[2] = sh[1]; sh[1] = sh[0]; sh[0] = src;
    nh[2] = nh[1]; nh[1] = nh[0]; nh[0] = nmi_src;
  endtask

  function automatic logic [7:0] model_rd(input logic [1:0] idx);
    logic [7:0] pe, lsb;
    pe  = pend_m & en_m;
    lsb = pe & (~pe + 8'd1);
    case (idx)
      2'd0:    return pend_m;
      2'd1:    return en_m;
      2'd2:    return edge_m;
      default: return {(pe != 8'h00), 4'b0000, 3'($clog2(lsb))};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("irq_model", {7'b0, irq}, {7'b0, irq_m});
    check("nmi_model", {7'b0, nmi}, {7'b0, nmi_m});
  endtask

  // full bus write: phi2 low for one clk, high for two
  task automatic wr(input logic [2:0] off, input logic [7:0] d);
    addr = BASE + 16'(off); odata = d; rw = 1'b0; clk2 = 1'b0;
    tick();
    clk2 = 1'b1; m_commit = (off < 3'd4); m_off = off[1:0]; m_data = d;
    tick();
    m_commit = 1'b0;
    tick();
    clk2 = 1'b0; rw = 1'b1; addr = 16'h0000;
  endtask

  task automatic rd(input logic [1:0] idx, input logic [7:0] exp, input string name);
    addr = BASE + 16'(idx); rw = 1'b1;
    #1;
    check(name, rdata, exp);
    check({name, "_rsel"}, {7'b0, rsel}, 8'h01);
    addr = 16'h0000;
  endtask

  task automatic rd_model(input logic [1:0] idx);
    addr = BASE + 16'(idx); rw = 1'b1;
    #1;
    check("rd_rand", rdata, model_rd(idx));
    addr = 16'h0000;
  endtask

  typedef struct {
    logic [2:0] off;
    logic       wr;
    logic [7:0] data;
    logic [1:0] idx;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lows, falls;
    logic prev;
    vecs = '{
      '{3'd0, 1'b0, 8'h00, 2'd0, 8'h00},
      '{3'd0, 1'b0, 8'h00, 2'd1, 8'h00},
      '{3'd0, 1'b0, 8'h00, 2'd2, 8'hFF},
      '{3'd0, 1'b0, 8'h00, 2'd3, 8'h00},
      '{3'd1, 1'b1, 8'h5A, 2'd1, 8'h5A},
      '{3'd2, 1'b1, 8'h0F, 2'd2, 8'h0F},
      '{3'd3, 1'b1, 8'h55, 2'd3, 8'h00},
      '{3'd4, 1'b1, 8'h33, 2'd1, 8'h5A},
      '{3'd4, 1'b1, 8'h33, 2'd2, 8'h0F},
      '{3'd2, 1'b1, 8'hFF, 2'd2, 8'hFF},
      '{3'd1, 1'b1, 8'h00, 2'd1, 8'h00},
      '{3'd0, 1'b1, 8'hFF, 2'd0, 8'h00}
    };
    model_clear();
    m_commit = 1'b0; m_off = 2'd0; m_data = 8'h00;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("reset_irq", {7'b0, irq}, 8'h01);
    check("reset_nmi", {7'b0, nmi}, 8'h01);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) wr(vecs[i].off, vecs[i].data);
      rd(vecs[i].idx, vecs[i].exp, $sformatf("tbl%0d", i));
    end

    addr = BASE + 16'd4; rw = 1'b1;
    #1;
    check("rsel_miss", {7'b0, rsel}, 8'h00);
    check("rdata_miss", rdata, 8'h00);
    addr = 16'h0000;

    // edge source latency and clear
    wr(3'd1, 8'h04);
    src = 8'h04; tick(); src = 8'h00;
    tick(); tick();
    check("edge_lat3", {7'b0, irq}, 8'h01);
    tick();
    check("edge_lat4", {7'b0, irq}, 8'h00);
    rd(2'd3, 8'h82, "index_src2");
    wr(3'd0, 8'h04);
    check("edge_clr", {7'b0, irq}, 8'h01);

    // priority and set-over-clear
    wr(3'd1, 8'hFF);
    src = 8'h22; tick(); src = 8'h00;
    repeat (4) tick();
    rd(2'd3, 8'h81, "index_prio");
    wr(3'd0, 8'h02);
    rd(2'd3, 8'h85, "index_after_clr");
    src = 8'h20; tick();
    wr(3'd0, 8'h20);
    src = 8'h00;
    rd(2'd0, 8'h20, "set_wins");
    wr(3'd0, 8'h20);
    rd(2'd0, 8'h00, "clr_bit5");
    check("irq_idle", {7'b0, irq}, 8'h01);

    // level mode
    wr(3'd2, 8'h00);
    wr(3'd1, 8'h01);
    src = 8'h01;
    repeat (4) tick();
    check("lvl_irq", {7'b0, irq}, 8'h00);
    wr(3'd0, 8'h01);
    rd(2'd0, 8'h01, "lvl_status");
    check("lvl_irq_held", {7'b0, irq}, 8'h00);
    src = 8'h00;
    repeat (3) tick();
    check("lvl_drop3", {7'b0, irq}, 8'h00);
    tick();
    check("lvl_drop4", {7'b0, irq}, 8'h01);
    wr(3'd2, 8'hFF);

    // a long phi2-high write must commit only once
    addr = BASE; odata = 8'h08; rw = 1'b0; clk2 = 1'b0;
    tick();
    clk2 = 1'b1; m_commit = 1'b1; m_off = 2'd0; m_data = 8'h08; src = 8'h08;
    tick();
    m_commit = 1'b0; src = 8'h00;
    repeat (6) tick();
    clk2 = 1'b0; rw = 1'b1; addr = 16'h0000;
    rd(2'd0, 8'h08, "commit_once");
    wr(3'd0, 8'h08);

    // NMI single and double edge
    for (int dbl = 0; dbl < 2; dbl++) begin
      lows = 0; falls = 0; prev = nmi;
      for (int k = 0; k < 14; k++) begin
        nmi_src = (k == 0) || (k == 2 && dbl == 1);
        tick();
        if (!nmi) lows++;
        if (prev && !nmi) falls++;
        prev = nmi;
      end
`ifdef IRQ_CTRL_NMI_EN
      check($sformatf("nmi_lows%0d", dbl), 8'(lows), (dbl == 1) ? 8'd6 : 8'd4);
      check($sformatf("nmi_falls%0d", dbl), 8'(falls), 8'd1);
`else
      check($sformatf("nmi_lows%0d", dbl), 8'(lows), 8'd0);
      check($sformatf("nmi_falls%0d", dbl), 8'(falls), 8'd0);
`endif
    end

    // asynchronous reset while irq (and nmi) are low
    wr(3'd1, 8'h01);
    src = 8'h01; nmi_src = 1'b1; tick(); src = 8'h00; nmi_src = 1'b0;
    repeat (3) tick();
    check("pre_reset_irq", {7'b0, irq}, 8'h00);
    #2 reset = 1'b0;
    #1;
    check("async_irq", {7'b0, irq}, 8'h01);
    check("async_nmi", {7'b0, nmi}, 8'h01);
    model_clear();
    repeat (2) tick();
    reset = 1'b1;
    rd(2'd2, 8'hFF, "post_reset_edge");
    rd(2'd1, 8'h00, "post_reset_en");

    // randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 5))
        0: begin src = 8'($urandom); tick(); end
        1: begin nmi_src = ~nmi_src; tick(); end
        2: wr(3'($urandom_range(0, 4)), 8'($urandom));
        3: rd_model(2'($urandom_range(0, 3)));
        default: tick();
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
